mem_bus_arbiter: RTL

Two-master arbiter that shares the single memory-map port of the multicycle RISC-V core between the core's fetch/load/store path (master 0) and a second bus master such as a UART program loader or DMA (master 1). It sits between the masters and `master_memory_map`. It grants the bus round-robin, with optional short locked bursts. It latches the winner's command, sequences one access at a time with a programmable wait-state count, and returns read data with a one-cycle acknowledge.

---
 rtl/mem_bus_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single memory-map port of the multicycle core between two bus
// masters: master 0 (core fetch/load/store) and master 1 (loader / DMA).
// One access is in flight at a time. The winner's command is latched at grant,
// driven onto the memory-map port for RD_LAT / WR_LAT cycles, and completed
// with a one-cycle acknowledge carrying the read data.
//
// Handshake: a master raises mX_req with mX_we/mX_addr/mX_wd/mX_lock valid
// and keeps req high until it sees mX_ack. Command inputs are captured in the
// cycle the arbiter grants, so they are don't-care from then on until the ack.
// mX_ack is a single-cycle pulse; on a read, mX_rd is valid while ack is high
// and then holds until the next read for that master completes. In the ack
// cycle the just-acked master's req is ignored, so a req that is simply held
// high is not served twice off one handshake. The one exception is a locked
// owner still inside its lock budget, which keeps the bus directly.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   m0_* / m1_*           master request side (req, we, lock, addr, wd in;
//                         ack, rd out)
//   bus_addr/bus_wd       address / write data to the memory map
//   bus_we/bus_re         single-cycle write / read strobes
//   bus_rd                read data from the memory map
//   grant                 one-hot owner during ACCESS, 00 otherwise
//   busy                  high while an access occupies the bus
//   dbg_state             current FSM state (0 = IDLE, 1 = ACCESS)
//   dbg_lock_cnt          number of consecutive locked re-grants so far
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 1,
    parameter int WR_LAT     = 1,
    parameter int MAX_LOCK   = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          m0_req,
    input  logic                          m0_we,
    input  logic                          m0_lock,
    input  logic [ADDR_WIDTH-1:0]         m0_addr,
    input  logic [DATA_WIDTH-1:0]         m0_wd,
    output logic                          m0_ack,
    output logic [DATA_WIDTH-1:0]         m0_rd,

    input  logic                          m1_req,
    input  logic                          m1_we,
    input  logic                          m1_lock,
    input  logic [ADDR_WIDTH-1:0]         m1_addr,
    input  logic [DATA_WIDTH-1:0]         m1_wd,
    output logic                          m1_ack,
    output logic [DATA_WIDTH-1:0]         m1_rd,

    output logic [ADDR_WIDTH-1:0]         bus_addr,
    output logic [DATA_WIDTH-1:0]         bus_wd,
    output logic                          bus_we,
    output logic                          bus_re,
    input  logic [DATA_WIDTH-1:0]         bus_rd,

    output logic [1:0]                    grant,
    output logic                          busy,
    output logic                          dbg_state,
    output logic [$clog2(MAX_LOCK+1)-1:0] dbg_lock_cnt
);

    localparam int LC_W  = $clog2(MAX_LOCK + 1);
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] RD_LIM   = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WR_LIM   = CNT_W'(WR_LAT);
    localparam logic [LC_W-1:0]  LOCK_MAX = LC_W'(MAX_LOCK);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;   // 1-based count of ACCESS cycles
    logic              last;       // index of the master granted last
    logic              owner_q;    // index of the current / previous owner
    logic              we_q;       // latched direction of the access
    logic              lock_q;     // owner's lock request at its grant
    logic [LC_W-1:0]   lock_cnt;   // locked re-grants in the current burst

    // Arbitration (only meaningful in IDLE)
    logic              req_eff0;
    logic              req_eff1;
    logic              owner_req;
    logic              lock_hold;
    logic              do_grant;
    logic              win;

    // Winner's command, muxed ahead of the latches
    logic              sel_we;
    logic              sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wd;

    logic [CNT_W-1:0]  lim;
    logic              done;

    // The acks are registered and high only during the IDLE cycle that
    // follows an access, so they double as the ack-cycle request mask.
    assign req_eff0  = m0_req & ~m0_ack;
    assign req_eff1  = m1_req & ~m1_ack;

    // Lock override looks at the raw request: a locked owner keeps the bus
    // straight out of its own ack cycle while its budget lasts.
    assign owner_req = owner_q ? m1_req : m0_req;
    assign lock_hold = lock_q & owner_req & (lock_cnt < LOCK_MAX);

    always_comb begin
        do_grant = 1'b0;
        win      = 1'b0;
        if (state == IDLE) begin
            if (lock_hold) begin
                do_grant = 1'b1;
                win      = owner_q;
            end else if (req_eff0 && req_eff1) begin
                do_grant = 1'b1;
                win      = ~last;
            end else if (req_eff0) begin
                do_grant = 1'b1;
                win      = 1'b0;
            end else if (req_eff1) begin
                do_grant = 1'b1;
                win      = 1'b1;
            end
        end
    end

    assign sel_we   = win ? m1_we   : m0_we;
    assign sel_lock = win ? m1_lock : m0_lock;
    assign sel_addr = win ? m1_addr : m0_addr;
    assign sel_wd   = win ? m1_wd   : m0_wd;

    assign lim  = we_q ? WR_LIM : RD_LIM;
    assign done = (state == ACCESS) && (wait_cnt == lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            last     <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            lock_q   <= 1'b0;
            lock_cnt <= '0;
            grant    <= 2'b00;
            bus_addr <= '0;
            bus_wd   <= '0;
            bus_we   <= 1'b0;
            bus_re   <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rd    <= '0;
            m1_rd    <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses by default.
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            bus_we <= 1'b0;
            bus_re <= 1'b0;

            case (state)
                IDLE: begin
                    if (do_grant) begin
                        state    <= ACCESS;
                        wait_cnt <= CNT_W'(1);
                        owner_q  <= win;
                        we_q     <= sel_we;
                        lock_q   <= sel_lock;
                        last     <= win;
                        // Counts only override re-grants; any ordinary grant
                        // starts a new burst.
                        lock_cnt <= lock_hold ? lock_cnt + LC_W'(1) : '0;
                        bus_addr <= sel_addr;
                        bus_wd   <= sel_wd;
                        bus_we   <= sel_we;
                        bus_re   <= ~sel_we;
                        grant    <= win ? 2'b10 : 2'b01;
                    end
                end

                ACCESS: begin
                    if (done) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        if (owner_q) begin
                            m1_ack <= 1'b1;
                            if (!we_q) begin
                                m1_rd <= bus_rd;
                            end
                        end else begin
                            m0_ack <= 1'b1;
                            if (!we_q) begin
                                m0_rd <= bus_rd;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy         = (state == ACCESS);
    assign dbg_state    = state;
    assign dbg_lock_cnt = lock_cnt;

endmodule
